// File: rtl/formula_isqrt_sum_pipe_pkg.sv
// formula_isqrt_pkg: shared width/latency helpers for the pipelined
// isqrt-sum block. Used by formula_isqrt_sum_pipe and isqrt_stage_pipe.
//   root_w(width)     : per-channel root width (width/2)
//   tree_levels(n)    : registered adder-tree levels (0 when n == 1)
//   out_w(width, n)   : result width (root width + max(levels, 1))
//   pipe_lat(width, n): cycles from arg_vld to res_vld
package formula_isqrt_pkg;

  function automatic int root_w(input int width);
    return width / 2;
  endfunction

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int out_w(input int width, input int n);
    return root_w(width) + ((n <= 1) ? 1 : $clog2(n));
  endfunction

  function automatic int pipe_lat(input int width, input int n);
    return root_w(width) + ((tree_levels(n) == 0) ? 1 : tree_levels(n));
  endfunction

endpackage

// File: rtl/formula_isqrt_sum_pipe_isqrt_stage_pipe.sv
// isqrt_stage_pipe: fully pipelined non-restoring integer square root,
// one root bit per stage, WIDTH/2 stages of latency.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   x_vld, x   : operand and its valid; stage data only loads on valid
//   y_vld, y   : floor(sqrt(x)) and its valid, WIDTH/2 cycles later
module isqrt_stage_pipe
  import formula_isqrt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  x_vld,
  input  logic [WIDTH-1:0]      x,
  output logic                  y_vld,
  output logic [WIDTH/2-1:0]    y
);

  localparam int RW    = root_w(WIDTH);
  // Remainder magnitude stays below 2^(RW+1)+1; one spare bit for margin.
  localparam int REM_W = RW + 3;
  localparam int DW    = REM_W + 2;

  genvar s;
  for (s = 0; s < RW; s++) begin : g_st
    logic                    vld_q;
    logic [RW-1:0]           q_q;
    logic                    in_vld;
    logic [WIDTH-1:0]        in_x;
    logic [RW-1:0]           in_q;
    logic signed [REM_W-1:0] in_r;
    logic [RW-1:0]           part;
    logic signed [DW-1:0]    d;
    logic signed [DW-1:0]    r_w;
    logic [RW-1:0]           q_nxt;

    if (s == 0) begin : g_in0
      assign in_vld = x_vld;
      assign in_x   = x;
      assign in_q   = '0;
      assign in_r   = '0;
      assign part   = '0;
    end else begin : g_inn
      assign in_vld = g_st[s-1].vld_q;
      assign in_x   = g_st[s-1].g_carry.x_q;
      assign in_q   = g_st[s-1].q_q;
      assign in_r   = g_st[s-1].g_carry.r_q;
      // Root bits are kept in their final positions; realign the partial root.
      assign part   = in_q >> (RW - s);
    end

    // Non-restoring step: subtract 4q+1 after a non-negative remainder,
    // add 4q+3 after a negative one; the new root bit is the new sign inverted.
    always_comb begin
      d     = {in_r, in_x[WIDTH-1 -: 2]};
      r_w   = in_r[REM_W-1] ? (d + {{(DW-RW-2){1'b0}}, part, 2'b11})
                            : (d - {{(DW-RW-2){1'b0}}, part, 2'b01});
      q_nxt = r_w[DW-1] ? in_q : (in_q | (RW'(1) << (RW - 1 - s)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        q_q   <= '0;
      end else begin
        vld_q <= in_vld;
        if (in_vld) q_q <= q_nxt;
      end
    end

    // The last stage only needs its root; remainder and operand stop here.
    if (s < RW - 1) begin : g_carry
      logic [WIDTH-1:0]        x_q;
      logic signed [REM_W-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          r_q <= '0;
        end else if (in_vld) begin
          x_q <= in_x << 2;
          r_q <= r_w[REM_W-1:0];
        end
      end
    end
  end

  assign y_vld = g_st[RW-1].vld_q;
  assign y     = g_st[RW-1].q_q;

endmodule

// File: rtl/formula_isqrt_sum_pipe.sv
// formula_isqrt_sum_pipe: N-channel pipelined sum of integer square roots,
// res = sum of isqrt(x[i]) over channels enabled by arg_mask.
// Latency pipe_lat(WIDTH, N) cycles, one sample per clock, no backpressure.
// Handshake: arg_vld qualifies x/arg_mask for that cycle only and every
// such cycle is accepted; res_vld is a one-cycle pulse per accepted sample
// and res holds its last value between pulses.
// Ports:
//   clk, rst_n        : clock, async active-low reset (clears all in-flight)
//   arg_vld, x        : sample valid, packed operands (channel i at [i*WIDTH +: WIDTH])
//   arg_mask          : per-channel enable, masked channels contribute 0
//   res_vld, res      : result pulse and sum
// Optional (macro FORMULA_ISQRT_SUM_ACC_EN):
//   acc_clr, acc      : running wrap-around sum of res, clear wins over add
module formula_isqrt_sum_pipe
  import formula_isqrt_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int WIDTH = 32,
  localparam int RW    = root_w(WIDTH),
  localparam int OUT_W = out_w(WIDTH, N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arg_vld,
  input  logic [N*WIDTH-1:0] x,
  input  logic [N-1:0]       arg_mask,
  output logic               res_vld,
  output logic [OUT_W-1:0]   res
`ifdef FORMULA_ISQRT_SUM_ACC_EN
  ,
  input  logic               acc_clr,
  output logic [OUT_W+15:0]  acc
`endif
);

  localparam int T      = tree_levels(N);
  localparam int LEAVES = 1 << T;

  logic [RW-1:0] root [N];
  logic [N-1:0]  root_vld;

  genvar i, k, j;
  for (i = 0; i < N; i++) begin : g_ch
    isqrt_stage_pipe #(.WIDTH(WIDTH)) u_isqrt (
      .clk   (clk),
      .rst_n (rst_n),
      .x_vld (arg_vld & arg_mask[i]),
      .x     (x[i*WIDTH +: WIDTH]),
      .y_vld (root_vld[i]),
      .y     (root[i])
    );
  end

  // Sample valid and mask travel alongside the root pipelines.
  logic [RW-1:0] vld_d;
  logic [N-1:0]  mask_d [RW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d <= '0;
      for (int s = 0; s < RW; s++) mask_d[s] <= '0;
    end else begin
      vld_d[0] <= arg_vld;
      if (arg_vld) mask_d[0] <= arg_mask;
      for (int s = 1; s < RW; s++) begin
        vld_d[s] <= vld_d[s-1];
        if (vld_d[s-1]) mask_d[s] <= mask_d[s-1];
      end
    end
  end

  // A channel's root is valid exactly when the sample is valid and enabled.
  always_ff @(posedge clk) begin
    if (rst_n) assert (root_vld == (mask_d[RW-1] & {N{vld_d[RW-1]}}));
  end

  // Level 0 is the combinational leaf row; level k holds RW+k bit sums.
  for (k = 0; k <= T; k++) begin : lvl
    localparam int CNT = 1 << (T - k);
    localparam int W   = RW + k;
    logic [W-1:0] node [CNT];
    logic         vld;

    if (k == 0) begin : g_leaf
      assign vld = vld_d[RW-1];
      for (j = 0; j < LEAVES; j++) begin : g_j
        if (j < N) begin : g_use
          // Masked channels hold stale roots; never let them into the sum.
          assign node[j] = mask_d[RW-1][j] ? root[j] : '0;
        end else begin : g_pad
          assign node[j] = '0;
        end
      end
    end else begin : g_sum
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          for (int n = 0; n < CNT; n++) node[n] <= '0;
        end else begin
          vld <= lvl[k-1].vld;
          if (lvl[k-1].vld) begin
            for (int n = 0; n < CNT; n++)
              node[n] <= {1'b0, lvl[k-1].node[2*n]} + {1'b0, lvl[k-1].node[2*n+1]};
          end
        end
      end
    end
  end

  if (T == 0) begin : g_out_reg
    // Single channel: no tree, so register the root once to keep the output registered.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_vld <= 1'b0;
        res     <= '0;
      end else begin
        res_vld <= lvl[0].vld;
        if (lvl[0].vld) res <= OUT_W'(lvl[0].node[0]);
      end
    end
  end else begin : g_out_tree
    assign res_vld = lvl[T].vld;
    assign res     = lvl[T].node[0];
  end

`ifdef FORMULA_ISQRT_SUM_ACC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= res_vld ? (OUT_W+16)'(res) : '0;
    end else if (res_vld) begin
      acc <= acc + (OUT_W+16)'(res);
    end
  end
`endif

endmodule

// File: tb/tb_formula_isqrt_sum_pipe.sv
module tb_formula_isqrt_sum_pipe;

  localparam int N     = 3;
  localparam int WIDTH = 32;
  localparam int OUT_W = 18;
  localparam int LAT   = 18;
  localparam int LAT1  = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               arg_vld;
  logic [N*WIDTH-1:0] x;
  logic [N-1:0]       arg_mask;
  logic               res_vld;
  logic [OUT_W-1:0]   res;

  logic               arg_vld1;
  logic [7:0]         x1;
  logic [0:0]         mask1;
  logic               res_vld1;
  logic [4:0]         res1;

`ifdef FORMULA_ISQRT_SUM_ACC_EN
  logic               acc_clr;
  logic [OUT_W+15:0]  acc;
  logic               acc_clr1;
  logic [20:0]        acc1;
`endif

  formula_isqrt_sum_pipe #(.N(N), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arg_vld  (arg_vld),
    .x        (x),
    .arg_mask (arg_mask),
    .res_vld  (res_vld),
    .res      (res)
`ifdef FORMULA_ISQRT_SUM_ACC_EN
    ,
    .acc_clr  (acc_clr),
    .acc      (acc)
`endif
  );

  formula_isqrt_sum_pipe #(.N(1), .WIDTH(8)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .arg_vld  (arg_vld1),
    .x        (x1),
    .arg_mask (mask1),
    .res_vld  (res_vld1),
    .res      (res1)
`ifdef FORMULA_ISQRT_SUM_ACC_EN
    ,
    .acc_clr  (acc_clr1),
    .acc      (acc1)
`endif
  );

  // ---------------- scoreboard ----------------
  int              vectors     = 0;
  int              miscompares = 0;
  longint          cyc         = 0;
  logic [OUT_W-1:0] exp_q[$];
  longint          exp_cyc_q[$];
  logic [OUT_W-1:0] last_exp   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the head of the queue at its exact cycle;
  // between pulses res must keep the last expected result.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      last_exp = '0;
    end else if (res_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious_res_vld", 64'd1, 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("res", 64'(res), 64'(last_exp));
        check("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end else begin
      check("res_hold", 64'(res), 64'(last_exp));
    end
  end

  // Independent reference: binary search for the largest r with r*r <= v.
  function automatic longint unsigned isqrt_ref(input longint unsigned v);
    longint unsigned lo = 0;
    longint unsigned hi = 65535;
    longint unsigned mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a1,
                      input logic [WIDTH-1:0] a0, input logic [N-1:0] m,
                      input logic [OUT_W-1:0] e);
    @(posedge clk); #1;
    arg_vld  = 1'b1;
    x        = {a2, a1, a0};
    arg_mask = m;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      arg_vld = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 60;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      arg_vld = 1'b0;
      budget--;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic run1(input logic [7:0] v, input logic m, input logic [4:0] e, input string tag);
    longint start;
    bit     seen = 0;
    @(posedge clk); #1;
    arg_vld1 = 1'b1; x1 = v; mask1 = m; start = cyc;
    @(posedge clk); #1;
    arg_vld1 = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (res_vld1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(cyc - start), 64'(LAT1));
    check({tag, "_res"}, 64'(res1), 64'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] r0, r1, r2;
    logic [N-1:0]     rm;
    logic [OUT_W-1:0] e;

    arg_vld = 0; x = '0; arg_mask = '0;
    arg_vld1 = 0; x1 = '0; mask1 = '0;
`ifdef FORMULA_ISQRT_SUM_ACC_EN
    acc_clr = 0; acc_clr1 = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_res_vld", 64'(res_vld), 64'd0);
    check("reset_res", 64'(res), 64'd0);
    rst_n = 1'b1;

    // Single sample: 1000 + 9 + 4.
    send(32'd1000000, 32'd81, 32'd16, 3'b111, 18'd1013);
    idle(1);
    drain();

    // Back-to-back perfect squares, then the all-ones maximum.
    for (int k = 0; k < 18; k++)
      send(WIDTH'(k*k), WIDTH'(k*k), WIDTH'(k*k), 3'b111, OUT_W'(3*k));
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 18'd196605);
    idle(1);
    drain();

    // Masks and boundary values.
    send(32'd100, 32'd49, 32'd25, 3'b010, 18'd7);
    send(32'd100, 32'd49, 32'd25, 3'b000, 18'd0);
    send(32'd100, 32'd49, 32'd25, 3'b101, 18'd15);
    send(32'd3, 32'd4, 32'd15, 3'b111, 18'd6);
    send(32'hFFFE_0001, 32'hFFFE_0000, 32'hFFFF_FFFE, 3'b111, 18'd196604);
    send(32'd0, 32'd1, 32'd0, 3'b111, 18'd1);
    idle(1);
    drain();

    // Sparse random samples against the reference model.
    for (int n = 0; n < 20; n++) begin
      r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
      rm = N'($urandom_range(0, 7));
      e  = '0;
      if (rm[0]) e += OUT_W'(isqrt_ref(64'(r0)));
      if (rm[1]) e += OUT_W'(isqrt_ref(64'(r1)));
      if (rm[2]) e += OUT_W'(isqrt_ref(64'(r2)));
      send(r2, r1, r0, rm, e);
      idle(2);
    end
    drain();

    // Reset with ten samples in flight: none of them may emerge.
    for (int n = 0; n < 10; n++) send(32'd100, 32'd49, 32'd25, 3'b111, 18'd22);
    @(negedge clk);
    rst_n = 1'b0;
    arg_vld = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("midrst_res_vld", 64'(res_vld), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(25);
    send(32'd100, 32'd49, 32'd25, 3'b111, 18'd22);
    idle(1);
    drain();

    // Single-channel narrow instance.
    run1(8'd255, 1'b1, 5'd15, "n1_max");
    run1(8'd16, 1'b1, 5'd4, "n1_sq");
    run1(8'd200, 1'b0, 5'd0, "n1_masked");

`ifdef FORMULA_ISQRT_SUM_ACC_EN
    @(posedge clk); #1; acc_clr = 1'b1;
    @(posedge clk); #1; acc_clr = 1'b0;
    check("acc_clr", 64'(acc), 64'd0);
    send(32'd16, 32'd0, 32'd0, 3'b100, 18'd4);
    send(32'd0, 32'd81, 32'd0, 3'b010, 18'd9);
    send(32'd1000000, 32'd0, 32'd0, 3'b100, 18'd1000);
    idle(1);
    drain();
    @(posedge clk); #1;
    check("acc_sum", 64'(acc), 64'd1013);
    send(32'd100, 32'd49, 32'd25, 3'b010, 18'd7);
    idle(1);
    begin
      bit hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
        @(posedge clk); #1;
        if (res_vld) begin acc_clr = 1'b1; hit = 1; end
      end
      check("acc_clr_hit", 64'(hit), 64'd1);
    end
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("acc_clr_load", 64'(acc), 64'd7);
    drain();
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
